// File: rtl/icache_ctrl_if.sv
// Fetch-side and refill-side signals of the instruction cache.
//   pc        : fetch address from the PC register (bits [1:0] ignored)
//   instr     : fetched instruction word
//   stall     : fetch cannot complete this cycle (inverse enables the PC register)
//   mem_req   : refill word request to main memory
//   mem_addr  : word-aligned refill address
//   mem_rdata : refill data, valid with mem_ack
//   mem_ack   : one-cycle acknowledge per refill word
// The slave modport is the cache; the master modport is the CPU/memory side.
interface icache_ctrl_if;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output pc, mem_rdata, mem_ack,
        input  instr, stall, mem_req, mem_addr
    );

    modport slave (
        input  pc, mem_rdata, mem_ack,
        output instr, stall, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller with zero-latency hits
// and a word-by-word refill from main memory.
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-high reset
//   bus   : icache_ctrl_if.slave (pc/instr/stall fetch side, mem_* refill side)
// instr/stall are combinational from pc so a hit completes in the same cycle.
module icache_ctrl #(
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic         clk,
    input  logic         reset,
    icache_ctrl_if.slave bus
);
    localparam int unsigned OB = $clog2(WORDS_PER_LINE);
    localparam int unsigned IB = $clog2(NUM_LINES);
    localparam int unsigned TB = 32 - 2 - OB - IB;
    localparam logic [31:0]   NOP       = 32'h0000_0013;
    localparam logic [OB-1:0] LAST_WORD = OB'(WORDS_PER_LINE - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t state_q, state_d;

    // Line storage: valid bits are reset, tags/data are not.
    logic [NUM_LINES-1:0] valid_q;
    logic [TB-1:0]        tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES][WORDS_PER_LINE];

    // Refill context latched at miss time so pc may move during the refill.
    logic [TB-1:0] fill_tag_q;
    logic [IB-1:0] fill_idx_q;
    logic [OB-1:0] cnt_q;

    logic [OB-1:0] pc_off;
    logic [IB-1:0] pc_idx;
    logic [TB-1:0] pc_tag;
    logic          unused_pc_bits;

    logic hit_c;
    logic start_fill;
    logic fill_we;
    logic fill_done;

    // Address split: tag | index | offset | byte
    assign pc_off         = bus.pc[2 +: OB];
    assign pc_idx         = bus.pc[2 + OB +: IB];
    assign pc_tag         = bus.pc[31 -: TB];
    assign unused_pc_bits = ^bus.pc[1:0];

    // Next-state, fetch outputs and refill control.
    always_comb begin
        state_d      = state_q;
        hit_c        = 1'b0;
        start_fill   = 1'b0;
        fill_we      = 1'b0;
        fill_done    = 1'b0;
        bus.instr    = NOP;
        bus.stall    = 1'b1;
        bus.mem_req  = 1'b0;
        bus.mem_addr = '0;

        case (state_q)
            IDLE: begin
                hit_c = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
                // Reset holds the fetch side stalled with a NOP.
                if (!reset) begin
                    if (hit_c) begin
                        bus.stall = 1'b0;
                        bus.instr = data_mem[pc_idx][pc_off];
                    end else begin
                        start_fill = 1'b1;
                        state_d    = REFILL;
                    end
                end
            end
            REFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {fill_tag_q, fill_idx_q, cnt_q, 2'b00};
                if (bus.mem_ack) begin
                    fill_we = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        fill_done = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, valid bits and refill context.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            cnt_q      <= '0;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_fill) begin
                fill_tag_q      <= pc_tag;
                fill_idx_q      <= pc_idx;
                cnt_q           <= '0;
                // Invalidate now so a partially refilled line never hits.
                valid_q[pc_idx] <= 1'b0;
            end
            if (fill_we) begin
                cnt_q <= fill_done ? '0 : cnt_q + OB'(1);
            end
            if (fill_done) begin
                valid_q[fill_idx_q] <= 1'b1;
            end
        end
    end

    // Tag and data arrays; writes only happen in REFILL.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[fill_idx_q][cnt_q] <= bus.mem_rdata;
        end
        if (fill_done) begin
            tag_mem[fill_idx_q] <= fill_tag_q;
        end
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus randomized fetches
// checked against an address-level cache model and a lazily randomized memory.
module tb_icache_ctrl;
    localparam int unsigned NL  = 16;
    localparam int unsigned WPL = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic reset;
    icache_ctrl_if bus ();

    icache_ctrl #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Model: each line remembers which 16-byte block it holds.
    bit          model_valid [NL];
    logic [31:0] model_blk   [NL];
    logic [31:0] mem_model   [logic [31:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (!mem_model.exists(a)) mem_model[a] = $urandom;
        return mem_model[a];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < int'(NL); i++) model_valid[i] = 1'b0;
    endfunction

    // Fetch one address; handles a refill if the model predicts a miss.
    // Called and returns positioned 1 time unit after a rising edge.
    task automatic fetch(input logic [31:0] addr, input int delay);
        logic [31:0] blk, base, exp_instr, exp_addr;
        int idx, nstall, exp_stall;
        bit exp_hit;
        blk       = addr >> 4;
        base      = blk << 4;
        idx       = int'(blk[3:0]);
        exp_instr = mem_rd({addr[31:2], 2'b00});
        exp_hit   = model_valid[idx] && (model_blk[idx] == blk);
        bus.pc    = addr;
        @(negedge clk);
        if (!exp_hit) begin
            checks++;
            if (bus.stall !== 1'b1 || bus.instr !== NOP || bus.mem_req !== 1'b0) begin
                errors++;
                $display("FAIL miss_detect pc=%h: stall=%b instr=%h mem_req=%b, want 1/%h/0",
                         addr, bus.stall, bus.instr, bus.mem_req, NOP);
            end
            nstall = 1;
            @(posedge clk); #1;
            for (int w = 0; w < int'(WPL); w++) begin
                exp_addr = base + 32'(4 * w);
                for (int d = 0; d <= delay; d++) begin
                    bus.mem_ack   = (d == delay);
                    bus.mem_rdata = (d == delay) ? mem_rd(exp_addr) : $urandom;
                    @(negedge clk);
                    checks++;
                    if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr ||
                        bus.stall !== 1'b1 || bus.instr !== NOP) begin
                        errors++;
                        $display("FAIL refill_req pc=%h w=%0d: req=%b addr=%h stall=%b instr=%h, want 1/%h/1/%h",
                                 addr, w, bus.mem_req, bus.mem_addr, bus.stall, bus.instr, exp_addr, NOP);
                    end
                    if (bus.stall === 1'b1) nstall++;
                    @(posedge clk); #1;
                end
                bus.mem_ack = 1'b0;
            end
            model_valid[idx] = 1'b1;
            model_blk[idx]   = blk;
            @(negedge clk);
            exp_stall = 1 + int'(WPL) * (delay + 1);
            checks++;
            if (nstall != exp_stall) begin
                errors++;
                $display("FAIL stall_cycles pc=%h: got %0d, want %0d", addr, nstall, exp_stall);
            end
        end
        checks++;
        if (bus.stall !== 1'b0 || bus.instr !== exp_instr || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL hit pc=%h: stall=%b instr=%h mem_req=%b, want 0/%h/0",
                     addr, bus.stall, bus.instr, bus.mem_req, exp_instr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pc = 32'h0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1 || bus.instr !== NOP || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: stall=%b instr=%h req=%b addr=%h, want 1/%h/0/0",
                     bus.stall, bus.instr, bus.mem_req, bus.mem_addr, NOP);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_cold_fetch();
        for (int i = 0; i < 4; i++) mem_model[32'(4 * i)] = 32'hA0 + 32'(i);
        fetch(32'h0000_0000, 0);
    endtask

    task automatic test_spatial_hit();
        fetch(32'h0000_000C, 0);
        fetch(32'h0000_0006, 0);
    endtask

    task automatic test_eviction();
        fetch(32'h0000_0100, 0);
        fetch(32'h0000_0104, 0);
        fetch(32'h0000_0000, 0);
        fetch(32'h0000_0108, 1);
    endtask

    task automatic test_slow_mem();
        fetch(32'h0000_0240, 3);
        for (int i = 0; i < 4; i++) fetch(32'h0000_0240 + 32'(4 * i), 0);
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] base;
        base = 32'h0000_0380;
        bus.pc = base;
        @(negedge clk);
        @(posedge clk); #1;
        for (int w = 0; w < 2; w++) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_rd(base + 32'(4 * w));
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'b0;
        // Move pc during the refill; the request must not follow it.
        bus.pc = 32'h0000_0444;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== base + 32'h8) begin
            errors++;
            $display("FAIL mid_refill_req: req=%b addr=%h, want 1/%h", bus.mem_req, bus.mem_addr, base + 32'h8);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.stall !== 1'b1 || bus.instr !== NOP) begin
            errors++;
            $display("FAIL reset_abort: req=%b addr=%h stall=%b instr=%h, want 0/0/1/%h",
                     bus.mem_req, bus.mem_addr, bus.stall, bus.instr, NOP);
        end
        model_clear();
        @(posedge clk); #1;
        reset = 1'b0;
        fetch(base, 0);
        fetch(32'h0000_0000, 0);
    endtask

    task automatic test_stray_ack();
        logic [31:0] exp;
        fetch(32'h0000_0384, 0);
        exp = mem_rd(32'h0000_0384);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (bus.instr !== exp || bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack_same: instr=%h stall=%b req=%b, want %h/0/0", bus.instr, bus.stall, bus.mem_req, exp);
        end
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.instr !== exp || bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack_after: instr=%h stall=%b req=%b, want %h/0/0", bus.instr, bus.stall, bus.mem_req, exp);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) fetch(32'h0000_0380 + 32'(4 * i), 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 60; n++) begin
            a = (32'($urandom_range(0, 63)) << 4) | 32'($urandom_range(0, 15));
            fetch(a, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_cold_fetch();
        test_spatial_hit();
        test_eviction();
        test_slow_mem();
        test_reset_mid_refill();
        test_stray_ack();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
